// File: rtl/serial_tx_arb_pkg.sv
// Shared definitions for the serial transmit arbiter and the bit-stuffed link it drives.
// The link constants are also used by the transmitter and receiver.
package serial_tx_arb_pkg;

  localparam int MSG_W      = 64;
  localparam int GROUPS     = 10;
  localparam int GROUP_BITS = 9;
  localparam int GAP_MIN    = 21;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/serial_tx_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping at N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   elig_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           any_o,
  output logic [IDW-1:0] idx_o
);

  // Padding to 2**IDW lets the IDW-bit candidate index the vector directly.
  logic [2**IDW-1:0] elig_pad;
  logic [IDW-1:0]    cand;

  always_comb begin
    elig_pad         = '0;
    elig_pad[N-1:0]  = elig_i;
    any_o            = 1'b0;
    idx_o            = '0;
    cand             = ptr_i;
    for (int i = 0; i < N; i++) begin
      cand = (cand == IDW'(N - 1)) ? '0 : cand + IDW'(1);
      if (!any_o && elig_pad[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arb.sv
// Round-robin arbiter/sequencer sharing one bit-stuffed serial transmitter among N requesters,
// with a launch watchdog, sticky timeout flag and completed-message counter.
module serial_tx_arb
  import serial_tx_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 3,
  parameter int TMO = 255,
  parameter int CW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       en_i,
  input  logic [N-1:0]       req_valid_i,
  input  logic [N*MSG_W-1:0] req_data_i,
  output logic [N-1:0]       req_ready_o,
  output logic [MSG_W-1:0]   tx_d_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  output logic [IDW-1:0]     grant_id_o,
  output logic               active_o,
  output logic               tmo_err_o,
  input  logic               clr_i,
  output logic [CW-1:0]      msg_cnt_o
);

  localparam int WDW = $clog2(TMO + 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic [MSG_W-1:0] tx_d_q, tx_d_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic             active_q, active_d;
  logic             tmo_err_q, tmo_err_d;
  logic [CW-1:0]    msg_cnt_q, msg_cnt_d;
  logic [WDW-1:0]   wd_q, wd_d;

  logic [N-1:0]     elig;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic [MSG_W-1:0] word_sel [2**IDW];

  assign elig = req_valid_i & en_i;

  for (genvar gi = 0; gi < 2**IDW; gi++) begin : g_word
    if (gi < N) begin : g_real
      assign word_sel[gi] = req_data_i[gi*MSG_W +: MSG_W];
    end else begin : g_pad
      assign word_sel[gi] = '0;
    end
  end

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // NOTE: every _d below gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_d_d      = tx_d_q;
    grant_d     = grant_q;
    active_d    = active_q;
    tmo_err_d   = tmo_err_q;
    msg_cnt_d   = msg_cnt_q;
    wd_d        = wd_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any && !tx_busy_i) begin
          grant_d  = pick_idx;
          rr_ptr_d = pick_idx;
          active_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        tx_d_d      = word_sel[grant_q];
        req_ready_d = N'(1) << grant_q;
        state_d     = START;
      end
      START: begin
        tx_start_d = 1'b1;
        wd_d       = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (wd_q == WDW'(TMO)) begin
          // The word was already accepted; it is dropped, not retried.
          tmo_err_d = 1'b1;
          active_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          msg_cnt_d = msg_cnt_q + CW'(1);
          active_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear on the same edge as a completion or timeout takes priority.
    if (clr_i) begin
      tmo_err_d = 1'b0;
      msg_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(N - 1);
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_d_q      <= '0;
      grant_q     <= '0;
      active_q    <= 1'b0;
      tmo_err_q   <= 1'b0;
      msg_cnt_q   <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_d_q      <= tx_d_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
      tmo_err_q   <= tmo_err_d;
      msg_cnt_q   <= msg_cnt_d;
      wd_q        <= wd_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign tx_start_o  = tx_start_q;
  assign tx_d_o      = tx_d_q;
  assign grant_id_o  = grant_q;
  assign active_o    = active_q;
  assign tmo_err_o   = tmo_err_q;
  assign msg_cnt_o   = msg_cnt_q;

endmodule

// File: tb/tb_serial_tx_arb.sv
// Scoreboard bench for serial_tx_arb: launches are queued as expected and popped by a monitor,
// directed scenarios check latency, fairness, masking, timeout, clear priority and reset.
module tb_serial_tx_arb;

  localparam int N   = 4;
  localparam int IDW = 3;
  localparam int TMO = 255;
  localparam int CW  = 16;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    data;
  } launch_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    en;
  logic [N-1:0]    req_valid;
  logic [N*64-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [63:0]     tx_d;
  logic            tx_start;
  logic            tx_busy;
  logic [IDW-1:0]  grant_id;
  logic            active;
  logic            tmo_err;
  logic            clr;
  logic [CW-1:0]   msg_cnt;

  logic [63:0] words [N];
  int          left [N];
  int          cnt [N];
  int          rdy_cnt [N];
  launch_t     exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          starts = 0;
  logic        model_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic        tx_mode = 1'b1;
  int          busy_len = 20;
  logic        clr_on_done = 1'b0;
  logic        clr_done = 1'b0;

  always #5 clk = ~clk;

  assign tx_busy  = model_busy | force_busy;
  assign req_data = {words[3], words[2], words[1], words[0]};

  serial_tx_arb #(.N(N), .IDW(IDW), .TMO(TMO), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_d_o      (tx_d),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .grant_id_o  (grant_id),
    .active_o    (active),
    .tmo_err_o   (tmo_err),
    .clr_i       (clr),
    .msg_cnt_o   (msg_cnt)
  );

  function automatic logic [63:0] make_word(input int i, input int n);
    return {8'(8'hA0 + i), 24'(n), 32'h5A5A_0000 | 32'(i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [63:0] d);
    launch_t e;
    e.id   = IDW'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_cnt(input int target, input int budget, input string name);
    for (int n = 0; n < budget && msg_cnt != CW'(target); n++) @(negedge clk);
    check(name, 64'(msg_cnt), 64'(target));
  endtask

  // Requesters: on each accept present the next word, drop valid once the quota is used.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst && req_ready[i]) begin
          rdy_cnt[i]++;
          cnt[i]++;
          words[i] = make_word(i, cnt[i]);
          if (left[i] > 0) left[i]--;
          if (left[i] == 0) req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy two cycles after launch, for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx_start && tx_mode) begin
        repeat (2) @(negedge clk);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
        if (clr_on_done) begin
          clr = 1'b1;
          @(negedge clk);
          clr      = 1'b0;
          clr_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every launch.
  initial begin
    launch_t    e;
    logic [3:0] rdy_prev   = '0;
    logic       start_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdy_prev   = '0;
        start_prev = 1'b0;
      end else begin
        if (tx_start) begin
          starts++;
          check("start_pulse_width", 64'(start_prev), 64'(0));
          if (exp_q.size() == 0) begin
            check("unexpected_launch", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("launch_id", 64'(grant_id), 64'(e.id));
            check("launch_data", tx_d, e.data);
            check("ready_before_start", 64'(rdy_prev), 64'(4'b0001 << e.id));
          end
        end
        if ($countones(req_ready) > 1) check("ready_onehot", 64'(req_ready), 64'(0));
        rdy_prev   = req_ready;
        start_prev = tx_start;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base;
    int s0;
    int r0 [N];
    rst = 1'b1; clr = 1'b0; en = '1; req_valid = '0;
    for (int i = 0; i < N; i++) begin
      words[i] = make_word(i, 0); left[i] = 0; cnt[i] = 0; rdy_cnt[i] = 0;
    end

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_d", tx_d, 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_active", 64'(active), 64'(0));
    check("rst_tmo_err", 64'(tmo_err), 64'(0));
    check("rst_msg_cnt", 64'(msg_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single requester with exact latency
    busy_len     = 1100;
    words[2]     = 64'h0123456789ABCDEF;
    left[2]      = 1;
    push_exp(2, 64'h0123456789ABCDEF);
    req_valid    = 4'b0100;
    @(negedge clk);
    check("t1_active_after_grant", 64'(active), 64'(1));
    check("t1_no_ready_yet", 64'(req_ready), 64'(0));
    check("t1_grant_id", 64'(grant_id), 64'(2));
    @(negedge clk);
    check("t1_ready_pulse", 64'(req_ready), 64'(4'b0100));
    check("t1_no_start_yet", 64'(tx_start), 64'(0));
    @(negedge clk);
    check("t1_start", 64'(tx_start), 64'(1));
    check("t1_tx_d", tx_d, 64'h0123456789ABCDEF);
    check("t1_ready_gone", 64'(req_ready), 64'(0));
    wait_cnt(1, 1300, "t1_msg_cnt");
    @(negedge clk);
    check("t1_active_done", 64'(active), 64'(0));
    check("t1_tx_d_hold", tx_d, 64'h0123456789ABCDEF);
    check("t1_rdy_count", 64'(rdy_cnt[2]), 64'(1));

    // Fairness from a fresh pointer
    busy_len = 20;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_exp(i, make_word(i, cnt[i] + r));
    for (int i = 0; i < N; i++) begin
      left[i] = 2; r0[i] = rdy_cnt[i];
    end
    req_valid = 4'b1111;
    wait_cnt(8, 600, "t2_msg_cnt");
    for (int i = 0; i < N; i++) check("t2_ready_twice", 64'(rdy_cnt[i] - r0[i]), 64'(2));

    // Mask and busy hold
    @(negedge clk);
    en = 4'b1010; force_busy = 1'b1;
    left[0] = 5; left[1] = 2; left[2] = 5; left[3] = 2;
    req_valid = 4'b1111;
    s0 = starts;
    repeat (50) @(negedge clk);
    check("t3_no_start_in_hold", 64'(starts), 64'(s0));
    check("t3_idle_inactive", 64'(active), 64'(0));
    push_exp(1, make_word(1, cnt[1]));
    push_exp(3, make_word(3, cnt[3]));
    push_exp(1, make_word(1, cnt[1] + 1));
    push_exp(3, make_word(3, cnt[3] + 1));
    force_busy = 1'b0;
    wait_cnt(12, 600, "t3_msg_cnt");
    req_valid = '0;
    en = '1;
    @(negedge clk);

    // Watchdog timeout, then next requester served
    tx_mode = 1'b0;
    left[0] = 1; left[1] = 1;
    push_exp(0, make_word(0, cnt[0]));
    push_exp(1, make_word(1, cnt[1]));
    req_valid = 4'b0011;
    for (int n = 0; n < 20 && !tx_start; n++) @(negedge clk);
    check("t4_launch_seen", 64'(tx_start), 64'(1));
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      if (n == 255) check("t4_no_tmo_at_255", 64'(tmo_err), 64'(0));
      if (n == 256) begin
        check("t4_tmo_at_256", 64'(tmo_err), 64'(1));
        check("t4_inactive", 64'(active), 64'(0));
        check("t4_cnt_unchanged", 64'(msg_cnt), 64'(12));
      end
    end
    tx_mode = 1'b1;
    wait_cnt(13, 200, "t4_next_served");
    check("t4_tmo_sticky", 64'(tmo_err), 64'(1));

    // Plain clear, then clear coinciding with completion
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_clr_tmo", 64'(tmo_err), 64'(0));
    check("t5_clr_cnt", 64'(msg_cnt), 64'(0));
    left[2] = 6;
    for (int r = 0; r < 6; r++) push_exp(2, make_word(2, cnt[2] + r));
    req_valid = 4'b0100;
    wait_cnt(5, 400, "t5_reach_5");
    clr_on_done = 1'b1;
    for (int n = 0; n < 200 && !clr_done; n++) begin
      @(negedge clk);
      #1;
    end
    check("t5_clr_seen", 64'(clr_done), 64'(1));
    check("t5_clr_wins_cnt", 64'(msg_cnt), 64'(0));
    check("t5_clr_wins_tmo", 64'(tmo_err), 64'(0));
    clr_on_done = 1'b0;
    @(negedge clk);

    // Reset in WAIT_DONE
    left[0] = 2; left[2] = 1;
    push_exp(0, make_word(0, cnt[0]));
    req_valid = 4'b0101;
    for (int n = 0; n < 40 && !(tx_busy && active); n++) @(negedge clk);
    check("t6_in_wait_done", 64'(tx_busy && active), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 64'(req_ready), 64'(0));
    check("t6_rst_start", 64'(tx_start), 64'(0));
    check("t6_rst_tx_d", tx_d, 64'(0));
    check("t6_rst_grant", 64'(grant_id), 64'(0));
    check("t6_rst_active", 64'(active), 64'(0));
    check("t6_rst_cnt", 64'(msg_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    push_exp(0, make_word(0, cnt[0]));
    push_exp(2, make_word(2, cnt[2]));
    wait_cnt(2, 300, "t6_after_rst");
    check("t6_last_grant", 64'(grant_id), 64'(2));
    req_valid = '0;

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_arb.md
Name: serial_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one bit-stuffed serial transmitter among N requesters.
- The link carries one 64-bit word per message: a start one, 10 × 9-bit groups (8 data bits plus a stuffed one), the last two groups CRC, then a zero gap of at least 21 ticks.
- The block accepts 64-bit words over valid/ready handshakes, picks one word at a time, and launches it on the transmitter with a one-clk start pulse.
- It tracks transmitter busy with a watchdog and keeps per-link status.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 3, width of grant_id; must satisfy 2**IDW ≥ N.
- TMO, 255, clk cycles allowed from tx_start to tx_busy rising before a timeout.
- CW, 16, width of msg_cnt.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  N  per-requester enable mask; a requester with en=0 is never granted.
- req_valid  in  N  word available; must stay high with stable data until the matching req_ready.
- req_data  in  N*64  word i on bits [64*i+63 : 64*i].
- req_ready  out  N  one-clk accept pulse, one-hot or zero.
- tx_d  out  64  word to the transmitter; stable from tx_start until tx_busy falls.
- tx_start  out  1  one-clk launch pulse.
- tx_busy  in  1  transmitter busy, including the inter-message gap.
- grant_id  out  IDW  index of the last granted requester.
- active  out  1  high from the grant until the message completes.
- tmo_err  out  1  sticky timeout flag.
- clr  in  1  synchronous clear of tmo_err and msg_cnt.
- msg_cnt  out  CW  completed messages, wraps at 2**CW.

Behaviour:
- Reset values (asynchronous): state=IDLE, rr_ptr=N-1, req_ready=0, tx_start=0, tx_d=0, grant_id=0, active=0, tmo_err=0, msg_cnt=0, watchdog=0. All outputs are registered.
- Eligibility: elig = req_valid & en. Search starts at (rr_ptr+1) mod N and wraps; the first eligible index wins.
- IDLE:
  - If elig≠0 and tx_busy=0, latch the winner g into grant_id and rr_ptr, set active=1, go to LOAD.
  - If tx_busy=1, stay in IDLE; the arbiter never launches over a busy transmitter.
- LOAD (1 cycle): tx_d ← word g, req_ready[g]=1 this cycle, go to START.
- START (1 cycle): tx_start=1, watchdog=0, go to WAIT_BUSY.
- Latency: valid seen at edge k gives req_ready high after edge k+1 and tx_start high after edge k+2.
- WAIT_BUSY:
  - tx_busy=1 → go to WAIT_DONE.
  - Otherwise the watchdog increments; when watchdog reaches TMO with tx_busy still 0: set tmo_err=1, active=0, go to IDLE. The word counts as consumed and is not retried.
- WAIT_DONE: on tx_busy=0, msg_cnt increments (wrapping), active=0, go to IDLE. There is no watchdog in this state, because the gap length is owned by the transmitter.
- Back-to-back: IDLE re-arbitrates on the cycle after WAIT_DONE exits. Each requester gets at most one grant per N grants while others are eligible.
- en cleared after a grant does not abort the in-flight message. req_valid dropping before req_ready is a protocol violation; the block still completes the sequence with the latched data.
- clr:
  - Clears tmo_err and msg_cnt on the next edge.
  - If clr coincides with a completion or a timeout, clr wins: the counter reads 0 and the flag reads 0.
- rst mid-message: everything returns to reset values immediately. tx_start is deasserted; no partial retry.
- tx_d holds its last value while in IDLE.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE);
  - the MSG_W=64 constant;
  - the link constants GROUPS=10, GROUP_BITS=9, GAP_MIN=21, shared with the transmitter and receiver.
- One sub-module, rr_pick: purely combinational. Inputs: elig[N], ptr. Outputs: any, idx[IDW]. Reused by other arbiters in the codebase.
- FSM, watchdog and counters stay in serial_tx_arb.

Test Plan:
- Single requester: N=4, en=4'hF, req_valid=4'b0100, data=64'h0123456789ABCDEF; transmitter model busy 1100 clks. Required: req_ready[2] pulses 1 cycle, tx_start 1 cycle later, tx_d=64'h0123456789ABCDEF, grant_id=2, msg_cnt=1 after busy falls.
- Fairness: all four valid continuously for 8 messages. Required grant order 0,1,2,3,0,1,2,3; each req_ready exactly twice.
- Mask and busy: en=4'b1010, all valid, tx_busy forced high in IDLE for 50 clks. Required: no tx_start during the hold, then grants alternate 1,3 only.
- Timeout: transmitter model never asserts busy, TMO=255. Required: tmo_err=1 exactly 256 cycles after tx_start; active=0; msg_cnt unchanged; next eligible requester is then served.
- Clear versus completion: clr asserted on the same edge that busy falls with msg_cnt=5. Required: msg_cnt=0, tmo_err=0.
- Reset mid-message: rst pulsed in WAIT_DONE. Required: all outputs at reset values within the same cycle; after release the same requester is regranted first from rr_ptr=N-1 (requester 0 if valid).
